alu_seq_unit: RTL and testbench

- Sequential, handshaked ALU execution unit. It sits on the responder side of the ALU operation interface.
- An initiator (control unit or bench) presents OP1/OP2/OPRN with a START pulse. The block latches the operands, executes, then returns OUT/ZERO with a one-cycle DONE pulse.
- Single-cycle ops complete in 1 cycle. Multiply uses an iterative shift-add datapath taking DATA_WIDTH cycles, replacing the combinational multiplier in the datapath.

---
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq_unit.sv | 130 +++++++++++++
 tb/tb_alu_seq_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between an ALU initiator and the sequential ALU unit.
interface alu_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
);
  logic                  start;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [OPRN_WIDTH-1:0] oprn;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;
  logic                  busy;
  logic                  done;

  modport master (
    output start, op1, op2, oprn,
    input  result, zero, busy, done
  );

  modport slave (
    input  start, op1, op2, oprn,
    output result, zero, busy, done
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative shift-add multiply.
// state | meaning: IDLE waits for start; EXEC writes a one-cycle result; MUL runs shift-add steps.
module alu_seq_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_seq_if.slave   alu_if
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]      CNT_INIT    = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
  localparam logic [DATA_WIDTH-1:0] SHIFT_LIMIT = DATA_WIDTH'(DATA_WIDTH);

  localparam logic [OPRN_WIDTH-1:0] OP_ADD = OPRN_WIDTH'(1);
  localparam logic [OPRN_WIDTH-1:0] OP_SUB = OPRN_WIDTH'(2);
  localparam logic [OPRN_WIDTH-1:0] OP_MUL = OPRN_WIDTH'(3);
  localparam logic [OPRN_WIDTH-1:0] OP_SRL = OPRN_WIDTH'(4);
  localparam logic [OPRN_WIDTH-1:0] OP_SLL = OPRN_WIDTH'(5);
  localparam logic [OPRN_WIDTH-1:0] OP_AND = OPRN_WIDTH'(6);
  localparam logic [OPRN_WIDTH-1:0] OP_OR  = OPRN_WIDTH'(7);
  localparam logic [OPRN_WIDTH-1:0] OP_NOR = OPRN_WIDTH'(8);
  localparam logic [OPRN_WIDTH-1:0] OP_SLT = OPRN_WIDTH'(9);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] op1_q;
  logic [DATA_WIDTH-1:0] op2_q;
  logic [OPRN_WIDTH-1:0] oprn_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic                  zero_q;
  logic                  busy_q;
  logic                  done_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0] mplier_q;

  logic [DATA_WIDTH-1:0] res_d;
  logic [DATA_WIDTH-1:0] acc_d;

  // Single-cycle result from the latched operands; unknown opcodes give zero.
  always_comb begin
    res_d = '0;
    case (oprn_q)
      OP_ADD: res_d = op1_q + op2_q;
      OP_SUB: res_d = op1_q - op2_q;
      OP_SRL: res_d = (op2_q >= SHIFT_LIMIT) ? '0 : (op1_q >> op2_q);
      OP_SLL: res_d = (op2_q >= SHIFT_LIMIT) ? '0 : (op1_q << op2_q);
      OP_AND: res_d = op1_q & op2_q;
      OP_OR:  res_d = op1_q | op2_q;
      OP_NOR: res_d = ~(op1_q | op2_q);
      OP_SLT: res_d = {{(DATA_WIDTH-1){1'b0}}, (op1_q < op2_q)};
      default: res_d = '0;
    endcase
  end

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      oprn_q   <= '0;
      out_q    <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (alu_if.start) begin
            op1_q  <= alu_if.op1;
            op2_q  <= alu_if.op2;
            oprn_q <= alu_if.oprn;
            busy_q <= 1'b1;
            if (alu_if.oprn == OP_MUL) begin
              state_q  <= S_MUL;
              cnt_q    <= CNT_INIT;
              acc_q    <= '0;
              mcand_q  <= alu_if.op1;
              mplier_q <= alu_if.op2;
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          out_q   <= res_d;
          zero_q  <= (res_d == '0);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_ONE;
          // Last step: the final partial product is folded straight into the result.
          if (cnt_q == CNT_ONE) begin
            out_q   <= acc_d;
            zero_q  <= (acc_d == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_if.result = out_q;
  assign alu_if.zero   = zero_q;
  assign alu_if.busy   = busy_q;
  assign alu_if.done   = done_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed cases, random ops against an arithmetic reference, handshake stress.
module tb_alu_seq_unit;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.DATA_WIDTH(DW), .OPRN_WIDTH(6)) bus ();

  alu_seq_unit #(.DATA_WIDTH(DW), .OPRN_WIDTH(6)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .alu_if (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, r;
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      6'h01: r = ua + ub;
      6'h02: r = ua - ub;
      6'h03: r = ua * ub;
      6'h04: r = (ub >= 32) ? 0 : (ua >> ub);
      6'h05: r = (ub >= 32) ? 0 : (ua << ub);
      6'h06: r = ua & ub;
      6'h07: r = ua | ub;
      6'h08: r = ~(ua | ub);
      6'h09: r = (ua < ub) ? 1 : 0;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input string tag);
    logic [31:0] exp_res;
    int          lat_exp;
    int          cycles;
    bit          seen;
    exp_res = ref_alu(op, a, b);
    lat_exp = (op == 6'h03) ? 32 : 1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op1   = a;
    bus.op2   = b;
    bus.oprn  = op;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, ".busy"}, bus.busy, 1);
    cycles = 0;
    seen   = 0;
    while (!seen && cycles < 40) begin
      if (scramble) begin
        bus.op1   = $urandom;
        bus.op2   = $urandom;
        bus.oprn  = 6'($urandom);
        bus.start = 1'($urandom);
      end
      @(posedge clk); #1;
      cycles++;
      if (bus.done) seen = 1;
    end
    bus.start = 1'b0;
    chk({tag, ".latency"}, cycles, lat_exp);
    chk({tag, ".out"}, bus.result, exp_res);
    chk({tag, ".zero"}, bus.zero, (exp_res == 0));
    chk({tag, ".busy_end"}, bus.busy, 0);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, bus.done, 0);
    chk({tag, ".out_hold"}, bus.result, exp_res);
  endtask

  initial begin
    int          n_done;
    bit          prev_done;
    logic [5:0]  acc_op;
    logic [31:0] acc_a, acc_b;
    logic [5:0]  pick_op;
    logic [5:0]  sc_ops[10];
    sc_ops = '{6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h00, 6'h3F};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op1   = '0;
    bus.op2   = '0;
    bus.oprn  = '0;
    #1;
    chk("reset.out", bus.result, 0);
    chk("reset.zero", bus.zero, 1);
    chk("reset.busy", bus.busy, 0);
    chk("reset.done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(6'h01, 32'd15, 32'd3, 0, "add15_3");
    run_op(6'h02, 32'd15, 32'd5, 0, "sub15_5");
    run_op(6'h01, 32'd15, 32'hFFFF_FFFB, 0, "add15_m5");
    run_op(6'h09, 32'd11, 32'd11, 0, "slt11_11");
    run_op(6'h09, 32'd11, 32'd15, 0, "slt11_15");
    run_op(6'h03, 32'd7, 32'd5, 1, "mul7_5");
    run_op(6'h03, 32'hFFFF_FFF9, 32'd5, 1, "mulm7_5");
    run_op(6'h03, 32'hFFFF_FFF9, 32'hFFFF_FFFB, 1, "mulm7_m5");
    run_op(6'h04, 32'h0F, 32'd2, 0, "srl0f_2");
    run_op(6'h04, 32'hFFFF_FFFF, 32'd2, 0, "srlff_2");
    run_op(6'h05, 32'd1, 32'd5, 0, "sll1_5");
    run_op(6'h05, 32'hFFFF_FFFF, 32'd5, 0, "sllff_5");
    run_op(6'h06, 32'hB, 32'h2, 0, "and");
    run_op(6'h07, 32'hB, 32'h2, 0, "or");
    run_op(6'h08, 32'hFFFF_FFF8, 32'd2, 0, "nor");
    run_op(6'h04, 32'hFFFF_FFFF, 32'd40, 0, "srl40");
    run_op(6'h05, 32'hFFFF_FFFF, 32'd40, 0, "sll40");
    run_op(6'h3F, 32'd9, 32'd9, 1, "op3f");
    run_op(6'h00, 32'd9, 32'd9, 0, "op00");

    // Reset in the middle of a multiply: outputs clear immediately and no DONE follows.
    run_op(6'h01, 32'd100, 32'd1, 0, "pre_rst");
    @(negedge clk);
    bus.start = 1'b1;
    bus.op1   = 32'd7;
    bus.op2   = 32'd5;
    bus.oprn  = 6'h03;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst.out", bus.result, 0);
    chk("midrst.zero", bus.zero, 1);
    chk("midrst.busy", bus.busy, 0);
    chk("midrst.done", bus.done, 0);
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) n_done++;
    end
    chk("midrst.no_activity", n_done, 0);
    run_op(6'h03, 32'd7, 32'd5, 0, "post_rst_mul");

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      int          sel;
      sel = $urandom_range(0, 11);
      if (sel == 10) pick_op = 6'h3F;
      else if (sel == 11) pick_op = 6'($urandom);
      else pick_op = 6'(sel);
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op(pick_op, ra, rb, 1, $sformatf("rnd%0d_op%0h", i, pick_op));
    end

    // START held high: accepts on every idle edge, results follow the accepted operands.
    @(negedge clk);
    bus.start = 1'b1;
    prev_done = 0;
    n_done    = 0;
    acc_op    = '0;
    acc_a     = '0;
    acc_b     = '0;
    for (int i = 0; i < 24; i++) begin
      bus.oprn = sc_ops[$urandom_range(0, 9)];
      bus.op1  = $urandom;
      bus.op2  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      if (!bus.busy) begin
        acc_op = bus.oprn;
        acc_a  = bus.op1;
        acc_b  = bus.op2;
      end
      @(posedge clk); #1;
      chk($sformatf("stress%0d.no_wide_done", i), (bus.done && prev_done), 0);
      if (bus.done) begin
        n_done++;
        chk($sformatf("stress%0d.out", i), bus.result, ref_alu(acc_op, acc_a, acc_b));
      end
      prev_done = bus.done;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("stress.done_count", n_done, 12);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
